apb_regfile_slave: RTL
======================

# apb_regfile_slave

Parametrised APB slave exposing a bank of `NUM_REGS` read/write registers of `DATA_W` bits to the APB master. It adds programmable wait states, out-of-range error signalling on `pslverr`, and per-register write pulses. The register contents are driven out to the core logic. It sits behind the APB master on the peripheral bus.

## Interface
- `DATA_W`, default 32: register and data-bus width, multiple of 8.
- `ADDR_W`, default 8: `paddr` width; `paddr` is a register index (not a byte address).
- `NUM_REGS`, default 16: number of registers, 1..2^ADDR_W.
- `WAIT_CYCLES`, default 0: extra ACCESS cycles before `pready`, 0..15.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `psel` in 1: APB select.
- `penable` in 1: APB enable (access phase).
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in `ADDR_W`: register index.
- `pwdata` in `DATA_W`: write data.
- `pstrb` in `DATA_W/8`: byte strobes; present only with `APB_SLV_PSTRB_EN`.
- `pready` out 1: transfer completes this cycle.
- `prdata` out `DATA_W`: read data, valid when `pready` and `!pwrite`.
- `pslverr` out 1: error, valid only when `pready`.
- `reg_q` out `NUM_REGS*DATA_W`: all register contents; register i is at `[i*DATA_W +: DATA_W]`.
- `wr_pulse` out `NUM_REGS`: one-cycle one-hot pulse, registered, the cycle after a committed write to register i.

## Operation
- FSM has two states:
  - IDLE (reset state).
  - ACCESS: holds a wait counter `wcnt`, width clog2(`WAIT_CYCLES`+1).
- IDLE → ACCESS when `psel && !penable` (setup phase); `wcnt` ← 0.
- ACCESS behaviour:
  - When `psel && penable` and `wcnt < WAIT_CYCLES`, `wcnt` increments.
  - When `psel && penable` and `wcnt == WAIT_CYCLES`, the transfer completes; next state is IDLE.
  - When `!psel || !penable` (protocol abort), go to IDLE. No commit, no `wr_pulse`.
- `pready` = (state == ACCESS) && `psel` && `penable` && (`wcnt == WAIT_CYCLES`). Combinational from state and inputs.
- Address decode: `paddr < NUM_REGS` is in range.
  - Out of range: `pslverr` = 1 with `pready`; a write is discarded; `prdata` = 0.
- Write commit on the rising edge where `pready && pwrite` and the address is in range:
  - `reg[paddr]` ← `pwdata`.
  - `wr_pulse[paddr]` = 1 for exactly the following cycle.
- Read: `prdata` = `reg[paddr]` while `pready && !pwrite`; otherwise `prdata` = 0.
- Back-to-back transfers: the setup phase of the next transfer is accepted in the IDLE cycle right after completion. No dead cycle beyond APB's own setup phase.
- `reg_q` always reflects the current register contents, including the cycle after a commit.

## Timing
- Reset values: all registers 0, `reg_q` 0, `wr_pulse` 0, state IDLE, `wcnt` 0. Consequently `pready`, `pslverr` and `prdata` are 0.
- Reset asserted mid-transfer: immediate return to IDLE. No commit, no pulse, and registers clear.
- Transfer length is 2 + `WAIT_CYCLES` cycles (setup + access + waits).
- `pready` is high for exactly one cycle per transfer.
- Write data is visible on `reg_q` one cycle after the `pready` edge, coincident with `wr_pulse`.
- Read data is valid combinationally in the `pready` cycle.
- If `pwrite`, `paddr` or `pwdata` change during ACCESS, the values sampled at the completing edge are the ones used. Master compliance is not checked.

## Configuration
- `APB_SLV_PSTRB_EN` defined:
  - `pstrb` port exists.
  - On a write commit, byte k of the register updates only if `pstrb[k]` = 1.
  - A write with `pstrb` = 0 still completes and still pulses `wr_pulse`.
  - Reads ignore `pstrb`.
- `APB_SLV_PSTRB_EN` undefined: no `pstrb` port; every write updates the full word.

## Test plan
Configuration for all scenarios: `DATA_W`=32, `NUM_REGS`=16, `WAIT_CYCLES`=2.
- Reset, then idle bus → `pready`=0, `prdata`=0, `reg_q`=0, `wr_pulse`=0.
- Write 0xDEADBEEF to index 3 → `pready` high in cycle 4 only; `reg_q[3]`=0xDEADBEEF and `wr_pulse`=16'h0008 one cycle later. Read of index 3 → `prdata`=0xDEADBEEF with `pslverr`=0.
- Write to index 20 → `pslverr`=1 with `pready`, no `wr_pulse`, `reg_q` unchanged. Read of index 20 → `prdata`=0, `pslverr`=1.
- Drop `penable` after 1 wait cycle during a write of 0x1234 to index 5 → no `pready`, `reg[5]` unchanged, FSM in IDLE. A next write to index 5 completes normally.
- Assert `rst_n`=0 during the wait phase of a write to index 1 that already holds 0x55 → `reg_q` all 0, `pready`=0, no pulse.
- With `APB_SLV_PSTRB_EN`: `reg[2]`=0x11223344, write 0xAABBCCDD with `pstrb`=4'b0101 → `reg[2]`=0x11BB33DD.

Source files
------------

// File: rtl/apb_regfile_slave_if.sv
// apb_regfile_slave_if: APB bus bundle between master and register-file slave.
// pstrb exists only when APB_SLV_PSTRB_EN is defined.
interface apb_regfile_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
`ifdef APB_SLV_PSTRB_EN
    logic [DATA_W/8-1:0] pstrb;
`endif
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
`ifdef APB_SLV_PSTRB_EN
        output pstrb,
`endif
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
`ifdef APB_SLV_PSTRB_EN
        input  pstrb,
`endif
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB register bank with wait states, out-of-range pslverr and write pulses.
// Optional byte-strobe writes enabled by defining APB_SLV_PSTRB_EN.
module apb_regfile_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    apb_regfile_slave_if.slave         bus,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        wr_pulse
);
    localparam int NB     = DATA_W / 8;
    localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                     state_q, state_d;
    logic [WCNT_W-1:0]          wcnt_q, wcnt_d;
    logic [NUM_REGS*DATA_W-1:0] reg_d;
    logic [NUM_REGS-1:0]        wr_pulse_q, wr_pulse_d;
    logic [NB-1:0]              strb;
    logic [DATA_W-1:0]          rd_word;
    logic                       last, xfer, in_range, commit;

`ifdef APB_SLV_PSTRB_EN
    assign strb = bus.pstrb;
`else
    assign strb = '1;
`endif

    assign last        = wcnt_q == WCNT_W'(WAIT_CYCLES);
    assign xfer        = bus.psel && bus.penable;
    assign in_range    = 32'(bus.paddr) < NUM_REGS;
    assign bus.pready  = (state_q == ACCESS) && xfer && last;
    assign bus.pslverr = bus.pready && !in_range;
    assign bus.prdata  = (bus.pready && !bus.pwrite) ? rd_word : '0;
    assign commit      = bus.pready && bus.pwrite && in_range;
    assign wr_pulse    = wr_pulse_q;

    // Next state: setup phase enters ACCESS, waits count up, completion or abort returns to IDLE
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (state_q == IDLE) begin
            state_d = (bus.psel && !bus.penable) ? ACCESS : IDLE;
            wcnt_d  = '0;
        end else if (!xfer || last) begin
            state_d = IDLE;
        end else begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    // Register read mux and byte-masked write with one-hot pulse on commit
    always_comb begin
        rd_word    = '0;
        reg_d      = reg_q;
        wr_pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.paddr == ADDR_W'(i)) begin
                rd_word = reg_q[i*DATA_W +: DATA_W];
                if (commit) begin
                    wr_pulse_d[i] = 1'b1;
                    for (int k = 0; k < NB; k++)
                        if (strb[k]) reg_d[i*DATA_W + k*8 +: 8] = bus.pwdata[k*8 +: 8];
                end
            end
        end
    end

    // State, wait counter, registers and pulse flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            reg_q      <= '0;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            reg_q      <= reg_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end
endmodule
